// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer widths, renderer write request and arbiter state encoding.
package fb_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 4;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fb_wr_t;
    typedef enum logic [1:0] {S_SCAN, S_DRAIN, S_CLEAR} fb_arb_state_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO of renderer write requests with full/empty flags.
module fb_wr_fifo import fb_pkg::*; #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  fb_wr_t din,
    output fb_wr_t head,
    output logic   full,
    output logic   empty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] ONE = (PW+1)'(1);
    fb_wr_t mem [FIFO_DEPTH];
    logic [PW:0] wp, rp;
    assign head  = mem[rp[PW-1:0]];
    assign empty = wp == rp;
    assign full  = wp[PW] != rp[PW] && wp[PW-1:0] == rp[PW-1:0];
    always_ff @(posedge clk) begin
        if (push) mem[wp[PW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + ONE;
            if (pop) rp <= rp + ONE;
        end
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the framebuffer RAM port between VGA reads, buffered renderer writes and
// a bulk clear engine; the clear engine exists only when FB_CLEAR_EN is defined.
module fb_port_arbiter import fb_pkg::*; #(
    parameter int FIFO_DEPTH = 16,
    parameter int FB_WORDS   = 384000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_active,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    fb_arb_state_t     state;
    fb_wr_t            head;
    logic              full, empty, push, pop, clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    assign wr_ready = !rst && !full;
    assign push     = wr_valid && wr_ready;
    assign pop      = !rst && !vga_active && state == S_DRAIN && !empty;
    assign vga_data = ram_rdata;
    fb_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .din({wr_addr, wr_data}), .head(head), .full(full), .empty(empty)
    );
    // Reset forces the port quiet; otherwise clear beats drain, and vga_active blocks both.
    assign ram_we    = clr_we || pop;
    assign ram_addr  = clr_we ? clr_addr : pop ? head.addr : rst ? '0 : vga_addr;
    assign ram_wdata = clr_we ? clr_data : pop ? head.data : '0;
`ifdef FB_CLEAR_EN
    localparam int CW = FB_WORDS > 1 ? $clog2(FB_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FB_WORDS - 1);
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] color;
    logic start;
    assign start      = clear_start && state != S_CLEAR;
    assign clr_we     = !rst && !vga_active && state == S_CLEAR;
    assign clr_addr   = ADDR_W'(cnt);
    assign clr_data   = color;
    assign clear_busy = !rst && state == S_CLEAR;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            color <= '0;
        end else if (start) begin
            cnt   <= '0;
            color <= clear_color;
        end else if (clr_we) begin
            cnt <= cnt == LAST ? '0 : cnt + CW'(1);
        end
    end
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_color};
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
    assign clear_busy   = 1'b0;
`endif
    // A clear_start seen in S_DRAIN still lets this cycle's pop complete.
    always_ff @(posedge clk) begin
        if (rst) state <= S_SCAN;
`ifdef FB_CLEAR_EN
        else if (start) state <= S_CLEAR;
        else if (state == S_CLEAR) state <= clr_we && cnt == LAST ? S_SCAN : S_CLEAR;
`endif
        else if (state == S_SCAN) state <= !vga_active && (!empty || push) ? S_DRAIN : S_SCAN;
        else state <= empty ? S_SCAN : S_DRAIN;
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed plus random stimulus scored against an ordered write model and RAM model.
module tb_fb_port_arbiter;
    import fb_pkg::*;
    localparam int DEPTH = 16;
    localparam int WORDS = 16;
    logic clk = 0, rst = 1, vga_active = 0, wr_valid = 0, clear_start = 0;
    logic wr_ready, clear_busy, ram_we;
    logic [ADDR_W-1:0] vga_addr = 0, wr_addr = 0, ram_addr;
    logic [DATA_W-1:0] wr_data = 0, clear_color = 0, vga_data, ram_wdata, ram_rdata = 0;
    logic [DATA_W-1:0] mem [64] = '{default: '0};
    int n_cmp = 0, n_bad = 0, n_wr = 0, clr_left = 0;
    logic [DATA_W-1:0] clr_col = 0;
    fb_wr_t exp_q[$];
    fb_wr_t e;
    logic was_busy;

    always #5 clk = ~clk;

    fb_port_arbiter #(.FIFO_DEPTH(DEPTH), .FB_WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .vga_active(vga_active), .vga_addr(vga_addr), .vga_data(vga_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[5:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[5:0]];
    end

    // Every write must be the next clear word while a clear is pending, else the oldest accepted write.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_we", ram_we, 0);
            check("rst_busy", clear_busy, 0);
            check("rst_ready", wr_ready, 0);
            check("rst_addr", ram_addr, 0);
            check("rst_wdata", ram_wdata, 0);
            exp_q.delete();
            clr_left = 0;
        end else begin
            was_busy = clr_left > 0;
            check("ready", wr_ready, exp_q.size() < DEPTH);
            check("busy", clear_busy, was_busy);
            check("vga_data", vga_data, ram_rdata);
            if (vga_active) begin
                check("act_we", ram_we, 0);
                check("act_addr", ram_addr, vga_addr);
            end
            if (ram_we) begin
                n_wr++;
                if (clr_left > 0) begin
                    check("clr_addr", ram_addr, WORDS - clr_left);
                    check("clr_data", ram_wdata, clr_col);
                    clr_left--;
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", ram_addr, e.addr);
                    check("wr_data", ram_wdata, e.data);
                end else begin
                    check("spurious_we", ram_we, 0);
                end
            end
            if (wr_valid && wr_ready) exp_q.push_back({wr_addr, wr_data});
`ifdef FB_CLEAR_EN
            if (clear_start && !was_busy) begin
                clr_left = WORDS;
                clr_col  = clear_color;
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] bits;
        int w0, t, run;
        logic acc, done;
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        check("ready_after_rst", wr_ready, 1);
        step();
        // single write in blanking lands the next cycle
        wr_valid = 1; wr_addr = 5; wr_data = 3;
        step();
        wr_valid = 0;
        @(negedge clk);
        check("w1_we", ram_we, 1);
        check("w1_addr", ram_addr, 5);
        check("w1_data", ram_wdata, 3);
        @(negedge clk);
        check("w1_done", ram_we, 0);
        step();
        // three writes held during active video, then drained back to back
        vga_active = 1;
        for (int k = 0; k < 3; k++) begin
            vga_addr = ADDR_W'($urandom_range(0, 63));
            wr_valid = 1; wr_addr = ADDR_W'(10 + k); wr_data = DATA_W'(k + 1);
            step();
        end
        wr_valid = 0;
        repeat (2) step();
        vga_active = 0;
        bits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bits[i] = ram_we;
        end
        check("blank_writes", $countones(bits), 3);
        check("consecutive", $countones(bits & (bits >> 1)), 2);
        step();
        // fill the FIFO during active video, 17th write waits for a pop
        w0 = n_wr;
        vga_active = 1;
        for (int k = 0; k < 16; k++) begin
            wr_valid = 1; wr_addr = ADDR_W'(32 + k); wr_data = DATA_W'(k);
            step();
        end
        wr_addr = 48; wr_data = 4'hc;
        @(negedge clk);
        check("full_ready", wr_ready, 0);
        repeat (3) step();
        check("full_ready_hold", wr_ready, 0);
        vga_active = 0;
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = wr_ready;
            step();
        end
        wr_valid = 0;
        check("accept17", acc, 1);
        repeat (30) step();
        check("drain17_count", n_wr - w0, 17);
        check("drain17_empty", exp_q.size(), 0);
`ifdef FB_CLEAR_EN
        // clear under 4-on/4-off video with a write pushed mid-clear
        vga_active = 1; clear_color = 7; clear_start = 1;
        step();
        clear_start = 0;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            vga_active = (c / 4) % 2 == 0;
            vga_addr = ADDR_W'($urandom_range(0, 63));
            wr_valid = c == 10; wr_addr = 3; wr_data = 9;
            step();
            done = c > 20 && clr_left == 0 && exp_q.size() == 0;
        end
        wr_valid = 0; vga_active = 0;
        check("clear_done", done, 1);
        repeat (3) step();
        for (int a = 0; a < 16; a++) check("clear_mem", mem[a], a == 3 ? 9 : 7);
        // reset in the middle of a clear with two writes queued
        clear_color = 2; clear_start = 1;
        step();
        clear_start = 0;
        wr_valid = 1; wr_addr = 60; wr_data = 5;
        step();
        wr_addr = 61;
        step();
        wr_valid = 0;
        t = 0;
        while (clr_left != 8 && t < 50) begin
            step();
            t++;
        end
        check("reached_addr8", clr_left, 8);
        rst = 1;
        repeat (2) step();
        rst = 0;
        w0 = n_wr;
        repeat (10) step();
        check("rst_no_writes", n_wr - w0, 0);
        check("rst_busy_after", clear_busy, 0);
        check("rst_ready_after", wr_ready, 1);
        for (int a = 0; a < 16; a++) check("rst_mem", mem[a], a < 8 ? 2 : 7);
        check("rst_mem60", mem[60], 0);
        check("rst_mem61", mem[61], 0);
`else
        // clear requests have no effect without the clear engine
        w0 = n_wr;
        clear_color = 7; clear_start = 1;
        step();
        clear_start = 0;
        repeat (20) step();
        check("noclear_writes", n_wr - w0, 0);
        check("noclear_busy", clear_busy, 0);
`endif
        // random traffic
        run = 0;
        for (int c = 0; c < 800; c++) begin
            if (run == 0) begin
                vga_active = !vga_active;
                run = $urandom_range(1, 12);
            end
            run--;
            vga_addr = ADDR_W'($urandom_range(0, 63));
            wr_valid = $urandom_range(0, 1) == 1;
            wr_addr = ADDR_W'($urandom_range(0, 63));
            wr_data = DATA_W'($urandom_range(0, 15));
            clear_start = $urandom_range(0, 99) == 0;
            clear_color = DATA_W'($urandom_range(0, 15));
            step();
        end
        wr_valid = 0; clear_start = 0; vga_active = 0;
        repeat (100) step();
        check("rand_fifo_drained", exp_q.size(), 0);
        check("rand_clear_done", clr_left, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Shares the single-port framebuffer RAM between three requesters: VGA scan-out reads, renderer pixel writes and a bulk clear engine. VGA reads own the port unconditionally during active video. Renderer writes are buffered in a small FIFO and drained during blanking. The block sits between the renderer/MCU interface and the framebuffer RAM, and feeds vga_color's addr/data path.

Parameters:
ADDR_W, 19, framebuffer address width
DATA_W, 4, colour-index width (colormap index)
FIFO_DEPTH, 16, renderer write FIFO entries (power of two, >=2)
FB_WORDS, 384000, framebuffer words cleared by the clear engine (192000 on small devices)

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous active-high reset
vga_active  in  1  scan-out is in the visible area (sx<=799 && sy<=479)
vga_addr  in  ADDR_W  scan-out read address
vga_data  out  DATA_W  read data to colormap, valid one cycle after vga_addr
wr_valid  in  1  renderer write request
wr_ready  out  1  FIFO can accept
wr_addr  in  ADDR_W  renderer write address
wr_data  in  DATA_W  renderer write colour index
clear_start  in  1  one-cycle pulse that starts a full clear
clear_color  in  DATA_W  fill colour, sampled on clear_start
clear_busy  out  1  clear in progress
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data (1-cycle latency)

Behaviour:
- Reset: FIFO empty, state S_SCAN, clear counter 0, clear_busy=0, ram_we=0, ram_addr=0, ram_wdata=0, wr_ready=0 while rst is high and 1 on the first cycle after.
- Port mux is combinational from the registered state, FIFO head and clear counter. vga_data = ram_rdata passthrough.
- Priority every cycle: vga_active (read, ram_addr=vga_addr, ram_we=0) > clear > FIFO drain > idle. Idle drives ram_addr=vga_addr, ram_we=0.
- FSM:
  - S_SCAN: port idle or reading. Goes to S_CLEAR on a clear_start pulse; otherwise goes to S_DRAIN when !vga_active and FIFO non-empty.
  - S_DRAIN: each cycle with !vga_active pops the head and asserts ram_we. Returns to S_SCAN when FIFO is empty. A clear_start here goes to S_CLEAR after the current pop.
  - S_CLEAR: each cycle with !vga_active writes clear_color at the counter address, then increments the counter. After address FB_WORDS-1: clear_busy=0 next cycle, return to S_SCAN.
- vga_active rising mid-drain or mid-clear suspends writes that same cycle, with no loss and no duplication. Writes resume when vga_active falls.
- FIFO: push when wr_valid && wr_ready; wr_ready = !full. Push and pop in the same cycle are legal when non-empty. A write accepted at cycle n reaches ram_we no earlier than n+1. Order is preserved.
- Renderer writes are accepted during a clear but held until the clear completes, so post-clear content always wins.
- clear_start while clear_busy=1 is ignored. clear_busy rises the cycle after clear_start.
- Counter width: ceil(log2(FB_WORDS)). The counter never exceeds FB_WORDS-1.
- Reset mid-operation aborts the clear and discards FIFO contents.

Optional Feature:
FB_CLEAR_EN
- Defined: clear engine, S_CLEAR and clear_busy are present as above.
- Undefined: clear_start and clear_color are ignored, clear_busy is tied 0, and the FSM has only S_SCAN and S_DRAIN.

Decomposition:
- fb_pkg: ADDR_W and DATA_W constants, typedef fb_wr_t {addr, data}, enum fb_arb_state_t {S_SCAN, S_DRAIN, S_CLEAR}.
- Sub-module fb_wr_fifo: synchronous FIFO of fb_wr_t with full/empty, parameterised by FIFO_DEPTH.

Test Plan:
- Reset held 3 cycles -> ram_we=0, clear_busy=0, wr_ready=0; one cycle after release wr_ready=1.
- vga_active=0, push addr=5 data=3 -> next cycle ram_we=1, ram_addr=5, ram_wdata=3; FIFO empty after.
- vga_active=1, push (10,1),(11,2),(12,3) -> ram_we stays 0 and ram_addr tracks vga_addr; after vga_active falls, three consecutive writes in order.
- vga_active=1, push 17 writes back-to-back -> wr_ready=0 after the 16th acceptance; 17th held until a pop in blanking, all 17 land in order.
- FB_WORDS=16, clear_start with clear_color=7, vga_active toggling 4 on/4 off -> exactly 16 writes of 7 to addr 0..15, none during active; a write pushed mid-clear lands after address 15; clear_busy falls after the last write.
- Assert rst at clear address 8 with 2 FIFO entries -> no further ram_we, clear_busy=0, FIFO empty; RAM addresses 8..15 are untouched.
